sram_port_arbiter: RTL

- Shares one single-ported synchronous SRAM (1-cycle read latency) between the instruction-fetch requester and the load/store requester of the CPU core.
- Accepts at most one request per cycle and routes the response back to the owner exactly one cycle later.
- Data side has fixed priority; a starvation counter forces an instruction grant after a bounded wait.
- Sits between mycpu core stages (IF, MEM) and the memory shell.

---
 rtl/cpu_mem_pkg.sv | 21 ++
 rtl/sram_port_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// cpu_mem_pkg : shared memory-path types and defaults for the mycpu core
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    localparam int c_SRAM_LATENCY   = 1;
    localparam int c_DEFAULT_ADDR_W = 32;
    localparam int c_DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } resp_owner_t;

endpackage

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// sram_port_arbiter : shares one 1-cycle-latency SRAM between IF and MEM
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = c_DEFAULT_ADDR_W,
    parameter int DATA_W       = c_DEFAULT_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic                grant_inst_dbg
);

    localparam int c_CNT_W = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);

    resp_owner_t        r_resp_owner;
    resp_owner_t        w_resp_owner_nxt;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               w_starved;
    logic               w_grant_inst;
    logic               w_grant_data;
    logic               r_grant_inst;

    generate
        if (STARVE_LIMIT == 0) begin : g_no_starve
            assign w_starved = 1'b0;
            always_ff @(posedge clk) begin
                r_starve_cnt <= '0;
            end
        end else begin : g_starve
            assign w_starved = (r_starve_cnt >= c_CNT_W'(STARVE_LIMIT));
            // Counts only refused cycles of a live fetch; saturates at the limit.
            always_ff @(posedge clk) begin
                if (reset || !inst_req || w_grant_inst) begin
                    r_starve_cnt <= '0;
                end else if (!w_starved) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (!reset) begin
            if (inst_req && data_req) begin
                w_grant_inst = w_starved;
                w_grant_data = !w_starved;
            end else begin
                w_grant_inst = inst_req;
                w_grant_data = data_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_owner <= RESP_NONE;
        end else begin
            r_resp_owner <= w_resp_owner_nxt;
        end
    end

    always_comb begin
        w_resp_owner_nxt = RESP_NONE;
        sram_en          = 1'b0;
        sram_we          = '0;
        sram_addr        = '0;
        sram_wdata       = '0;
        if (w_grant_data) begin
            w_resp_owner_nxt = RESP_DATA;
            sram_en          = 1'b1;
            sram_we          = data_we;
            sram_addr        = data_addr;
            sram_wdata       = data_wdata;
        end else if (w_grant_inst) begin
            w_resp_owner_nxt = RESP_INST;
            sram_en          = 1'b1;
            sram_addr        = inst_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_inst <= 1'b0;
        end else if (w_grant_inst || w_grant_data) begin
            r_grant_inst <= w_grant_inst;
        end
    end

    assign inst_addr_ok   = w_grant_inst;
    assign data_addr_ok   = w_grant_data;
    // A response still in flight when reset arrives is dropped, not delivered.
    assign inst_data_ok   = (r_resp_owner == RESP_INST) && !reset;
    assign data_data_ok   = (r_resp_owner == RESP_DATA) && !reset;
    assign inst_rdata     = sram_rdata;
    assign data_rdata     = sram_rdata;
    assign grant_inst_dbg = r_grant_inst;

endmodule

`default_nettype wire
